tconv_pass_scheduler: RTL and testbench

- Sequences one transpose-convolution pass through the weight BRAM → ifmap BRAM → 16-PE compute array → accumulation datapath.
- Issues the BRAM read strobes and addresses, the PE load, psum and clear enables, and the output-column sweep.
- Sits between the layer-level FSM (start/done plus config) and the external control inputs of the datapath top level.
- One pass = one weight row broadcast to all PEs, then cfg_if_len ifmap elements streamed from one ifmap BRAM.

---
 rtl/tconv_pass_scheduler_pkg.sv | 20 ++
 rtl/tconv_pass_scheduler_addr_gen.sv | 37 +++
 rtl/tconv_pass_scheduler.sv | 171 +++++++++++++++++
 tb/tb_tconv_pass_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tconv_pass_scheduler_pkg.sv
// Shared types and constants for the transpose-convolution pass scheduler.
// Holds the pass state encoding and array/BRAM timing constants.
package tconv_pass_scheduler_pkg;

    localparam int NUM_BRAMS_DEF = 16;
    localparam int BRAM_RD_LAT   = 1;
    localparam int SWEEP_W       = 5;

    typedef enum logic [2:0] {
        IDLE,
        W_RD,
        W_LOAD,
        CLR,
        IF_STREAM,
        DRAIN,
        OUT_SWEEP,
        DONE
    } state_t;

endpackage

// File: rtl/tconv_pass_scheduler_addr_gen.sv
// Builds a one-hot read-enable vector and a flat per-lane address bus.
// Only the selected lane carries base+idx; all other lanes read address 0.
module tconv_addr_gen
    import tconv_pass_scheduler_pkg::*;
#(
    parameter int LANES  = NUM_BRAMS_DEF,
    parameter int ADDR_W = 10,
    parameter int IDX_W  = 10,
    parameter int SEL_W  = 4
) (
    input  logic                    en,
    input  logic [ADDR_W-1:0]       base,
    input  logic [IDX_W-1:0]        idx,
    input  logic [SEL_W-1:0]        lane,
    output logic [LANES-1:0]        re,
    output logic [LANES*ADDR_W-1:0] addr_flat
);

    logic [ADDR_W-1:0] addr;

    // Truncating the sum gives modulo-2^ADDR_W wrap for free.
    assign addr = base + ADDR_W'(idx);

    always_comb begin
        re        = '0;
        addr_flat = '0;
        if (en) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane == SEL_W'(l)) begin
                    re[l]                       = 1'b1;
                    addr_flat[l*ADDR_W +: ADDR_W] = addr;
                end
            end
        end
    end

endmodule

// File: rtl/tconv_pass_scheduler.sv
// Sequences one transpose-conv pass: weight row read/load, psum clear,
// ifmap stream, array drain, then an output column sweep.
module tconv_pass_scheduler
    import tconv_pass_scheduler_pkg::*;
#(
    parameter int NUM_BRAMS = NUM_BRAMS_DEF,
    parameter int W_ADDR_W  = 10,
    parameter int I_ADDR_W  = 10,
    parameter int LEN_W     = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [W_ADDR_W-1:0]           cfg_w_base,
    input  logic [I_ADDR_W-1:0]           cfg_if_base,
    input  logic [3:0]                    cfg_if_bram,
    input  logic [LEN_W-1:0]              cfg_if_len,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_BRAMS-1:0]          w_re,
    output logic [NUM_BRAMS*W_ADDR_W-1:0] w_addr_rd_flat,
    output logic [NUM_BRAMS-1:0]          if_re,
    output logic [NUM_BRAMS*I_ADDR_W-1:0] if_addr_rd_flat,
    output logic [3:0]                    ifmap_sel,
    output logic [NUM_BRAMS-1:0]          en_weight_load,
    output logic [NUM_BRAMS-1:0]          en_ifmap_load,
    output logic [NUM_BRAMS-1:0]          en_psum,
    output logic [NUM_BRAMS-1:0]          clear_psum,
    output logic [NUM_BRAMS-1:0]          en_output,
    output logic [NUM_BRAMS-1:0]          ifmap_sel_ctrl,
    output logic [4:0]                    done_select
);

    localparam logic [SWEEP_W-1:0] LAST_COL = SWEEP_W'(NUM_BRAMS - 1);
    localparam logic [NUM_BRAMS-1:0] CTRL_MASK = {{(NUM_BRAMS-1){1'b1}}, 1'b0};

    state_t                        state;
    logic [W_ADDR_W-1:0]           w_base_q;
    logic [I_ADDR_W-1:0]           if_base_q;
    logic [3:0]                    if_bram_q;
    logic [LEN_W-1:0]              len_q;
    logic [LEN_W-1:0]              elem;
    logic [SWEEP_W-1:0]            col;
    logic [NUM_BRAMS-1:0]          ag_re;
    logic [NUM_BRAMS*I_ADDR_W-1:0] ag_addr;

    tconv_addr_gen #(
        .LANES  (NUM_BRAMS),
        .ADDR_W (I_ADDR_W),
        .IDX_W  (LEN_W),
        .SEL_W  (4)
    ) u_if_addr (
        .en        (state == IF_STREAM),
        .base      (if_base_q),
        .idx       (elem),
        .lane      (if_bram_q),
        .re        (ag_re),
        .addr_flat (ag_addr)
    );

    // Outputs are registered from the current state, so each phase
    // becomes visible on the edge after the state is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            w_base_q        <= '0;
            if_base_q       <= '0;
            if_bram_q       <= '0;
            len_q           <= '0;
            elem            <= '0;
            col             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            w_re            <= '0;
            w_addr_rd_flat  <= '0;
            if_re           <= '0;
            if_addr_rd_flat <= '0;
            ifmap_sel       <= '0;
            en_weight_load  <= '0;
            en_ifmap_load   <= '0;
            en_psum         <= '0;
            clear_psum      <= '0;
            en_output       <= '0;
            ifmap_sel_ctrl  <= '0;
            done_select     <= '0;
        end else begin
            busy            <= (state != IDLE);
            done            <= 1'b0;
            w_re            <= '0;
            w_addr_rd_flat  <= '0;
            if_re           <= ag_re;
            if_addr_rd_flat <= ag_addr;
            ifmap_sel       <= '0;
            en_weight_load  <= '0;
            en_ifmap_load   <= '0;
            en_psum         <= '0;
            clear_psum      <= '0;
            en_output       <= '0;
            ifmap_sel_ctrl  <= '0;
            done_select     <= '0;

            unique case (state)
                IDLE: begin
                    if (start && !busy) begin
                        w_base_q  <= cfg_w_base;
                        if_base_q <= cfg_if_base;
                        if_bram_q <= cfg_if_bram;
                        len_q     <= cfg_if_len;
                        state     <= W_RD;
                    end
                end
                W_RD: begin
                    w_re           <= '1;
                    w_addr_rd_flat <= {NUM_BRAMS{w_base_q}};
                    state          <= W_LOAD;
                end
                W_LOAD: begin
                    en_weight_load <= '1;
                    state          <= CLR;
                end
                CLR: begin
                    clear_psum <= '1;
                    elem       <= '0;
                    col        <= '0;
                    state      <= (len_q == '0) ? OUT_SWEEP : IF_STREAM;
                end
                IF_STREAM: begin
                    ifmap_sel <= if_bram_q;
                    // Compute trails the first read by the BRAM latency.
                    if (elem != '0) begin
                        en_ifmap_load  <= '1;
                        en_psum        <= '1;
                        ifmap_sel_ctrl <= CTRL_MASK;
                    end
                    if (elem == len_q - LEN_W'(1)) begin
                        state <= DRAIN;
                    end else begin
                        elem <= elem + LEN_W'(1);
                    end
                end
                DRAIN: begin
                    en_ifmap_load  <= '1;
                    en_psum        <= '1;
                    ifmap_sel_ctrl <= CTRL_MASK;
                    if (col == LAST_COL) begin
                        col   <= '0;
                        state <= OUT_SWEEP;
                    end else begin
                        col <= col + SWEEP_W'(1);
                    end
                end
                OUT_SWEEP: begin
                    en_output   <= '1;
                    done_select <= col;
                    if (col == LAST_COL) begin
                        col   <= '0;
                        state <= DONE;
                    end else begin
                        col <= col + SWEEP_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tconv_pass_scheduler.sv
// Directed bench for tconv_pass_scheduler: full passes, len=0, address
// wrap, ignored restart with config churn, and async reset mid-pass.
module tb_tconv_pass_scheduler;

    localparam int N = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [9:0]   cfg_w_base;
    logic [9:0]   cfg_if_base;
    logic [3:0]   cfg_if_bram;
    logic [9:0]   cfg_if_len;
    logic         busy;
    logic         done;
    logic [15:0]  w_re;
    logic [159:0] w_addr_rd_flat;
    logic [15:0]  if_re;
    logic [159:0] if_addr_rd_flat;
    logic [3:0]   ifmap_sel;
    logic [15:0]  en_weight_load;
    logic [15:0]  en_ifmap_load;
    logic [15:0]  en_psum;
    logic [15:0]  clear_psum;
    logic [15:0]  en_output;
    logic [15:0]  ifmap_sel_ctrl;
    logic [4:0]   done_select;

    int n_checks = 0;
    int n_fail   = 0;

    tconv_pass_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_w_base      (cfg_w_base),
        .cfg_if_base     (cfg_if_base),
        .cfg_if_bram     (cfg_if_bram),
        .cfg_if_len      (cfg_if_len),
        .busy            (busy),
        .done            (done),
        .w_re            (w_re),
        .w_addr_rd_flat  (w_addr_rd_flat),
        .if_re           (if_re),
        .if_addr_rd_flat (if_addr_rd_flat),
        .ifmap_sel       (ifmap_sel),
        .en_weight_load  (en_weight_load),
        .en_ifmap_load   (en_ifmap_load),
        .en_psum         (en_psum),
        .clear_psum      (clear_psum),
        .en_output       (en_output),
        .ifmap_sel_ctrl  (ifmap_sel_ctrl),
        .done_select     (done_select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] obs,
                         input logic [159:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 160'(busy), '0);
        check({tag, " done"}, 160'(done), '0);
        check({tag, " w_re"}, 160'(w_re), '0);
        check({tag, " w_addr"}, w_addr_rd_flat, '0);
        check({tag, " if_re"}, 160'(if_re), '0);
        check({tag, " if_addr"}, if_addr_rd_flat, '0);
        check({tag, " psum"}, 160'(en_psum), '0);
        check({tag, " clr"}, 160'(clear_psum), '0);
        check({tag, " out"}, 160'(en_output), '0);
    endtask

    // Starts a pass and checks every output cycle by cycle against the
    // hand-derived timeline; poke re-pulses start and churns config at c10.
    task automatic run_pass(input logic [9:0] wb, input logic [9:0] ib,
                            input logic [3:0] br, input logic [9:0] len,
                            input bit poke);
        int L;
        int s;
        int last;
        logic [159:0] e_waddr;
        logic [159:0] e_iaddr;
        logic [15:0]  e_ifre;
        logic [15:0]  ones;
        logic [15:0]  ctrl;
        bit           strm;
        bit           comp;
        bit           swp;
        ones = '1;
        ctrl = 16'hFFFE;
        L    = int'(len);
        s    = (L > 0) ? 4 + L + N : 4;
        last = s + N;
        cfg_w_base  = wb;
        cfg_if_base = ib;
        cfg_if_bram = br;
        cfg_if_len  = len;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= last + 1; n++) begin
            @(posedge clk);
            #1;
            if (poke && n == 10) begin
                start       = 1'b1;
                cfg_w_base  = ~wb;
                cfg_if_base = ib + 10'h055;
                cfg_if_bram = br + 4'd1;
                cfg_if_len  = len + 10'd3;
            end
            if (poke && n == 11) start = 1'b0;
            strm = (L > 0) && (n >= 4) && (n <= 3 + L);
            comp = (L > 0) && (n >= 5) && (n <= 3 + L + N);
            swp  = (n >= s) && (n < s + N);
            e_waddr = '0;
            if (n == 1) e_waddr = {N{wb}};
            e_iaddr = '0;
            e_ifre  = '0;
            if (strm) begin
                e_iaddr[int'(br)*10 +: 10] = ib + 10'(n - 4);
                e_ifre[br] = 1'b1;
            end
            check($sformatf("c%0d busy", n), 160'(busy),
                  160'(n <= last));
            check($sformatf("c%0d done", n), 160'(done),
                  160'(n == last));
            check($sformatf("c%0d w_re", n), 160'(w_re),
                  (n == 1) ? 160'(ones) : '0);
            check($sformatf("c%0d w_addr", n), w_addr_rd_flat, e_waddr);
            check($sformatf("c%0d wload", n), 160'(en_weight_load),
                  (n == 2) ? 160'(ones) : '0);
            check($sformatf("c%0d clr", n), 160'(clear_psum),
                  (n == 3) ? 160'(ones) : '0);
            check($sformatf("c%0d if_re", n), 160'(if_re), 160'(e_ifre));
            check($sformatf("c%0d if_addr", n), if_addr_rd_flat, e_iaddr);
            check($sformatf("c%0d if_sel", n), 160'(ifmap_sel),
                  strm ? 160'(br) : '0);
            check($sformatf("c%0d if_load", n), 160'(en_ifmap_load),
                  comp ? 160'(ones) : '0);
            check($sformatf("c%0d psum", n), 160'(en_psum),
                  comp ? 160'(ones) : '0);
            check($sformatf("c%0d sel_ctrl", n), 160'(ifmap_sel_ctrl),
                  comp ? 160'(ctrl) : '0);
            check($sformatf("c%0d out", n), 160'(en_output),
                  swp ? 160'(ones) : '0);
            check($sformatf("c%0d dsel", n), 160'(done_select),
                  swp ? 160'(n - s) : '0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        cfg_w_base  = '0;
        cfg_if_base = '0;
        cfg_if_bram = '0;
        cfg_if_len  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("idle");

        run_pass(10'h010, 10'h020, 4'd3, 10'd4, 1'b0);
        run_pass(10'h155, 10'h100, 4'd7, 10'd0, 1'b0);
        run_pass(10'h2AA, 10'h3FE, 4'd15, 10'd4, 1'b0);
        run_pass(10'h033, 10'h044, 4'd0, 10'd6, 1'b1);
        // the ignored restart must not have queued a second pass
        repeat (3) begin
            @(posedge clk);
            #1;
            check("post-poke busy", 160'(busy), '0);
        end
        run_pass(10'h001, 10'h002, 4'd9, 10'd2, 1'b0);

        cfg_w_base  = 10'h0AB;
        cfg_if_base = 10'h0CD;
        cfg_if_bram = 4'd5;
        cfg_if_len  = 10'd8;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid if_re", 160'(if_re), 160'(16'h0020));
        check("mid busy", 160'(busy), 160'(1'b1));
        #2 rst = 1'b1;
        #1;
        check_all_zero("async rst");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-rst k%0d done", k), 160'(done), '0);
            check($sformatf("post-rst k%0d busy", k), 160'(busy), '0);
        end
        run_pass(10'h010, 10'h020, 4'd3, 10'd4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
